phy_rx_lane_ctrl: RTL and testbench
===================================

# phy_rx_lane_ctrl

Receive-side lane controller for the two-lane serial PHY. It takes the two raw serial bit streams (`in_data_serie_0`, `in_data_serie_1`), finds byte alignment on each lane by searching for the 0xBC comma symbol, and declares lock after a run of aligned commas. Once locked, it reports completed data bytes per lane and raises `active_out` when both lanes are locked. It sits between the serial inputs and the byte-level deserialize/unstripe logic of `phy_rx`, and gates that logic's `valid`.

## Interface
- `COMMA`, 8'hBC: alignment/idle symbol.
- `LOCK_COUNT`, 4: consecutive aligned commas required for lock (2..15), counting the first detection.
- `clk` input 1: single clock; one serial bit is sampled per lane on each rising edge.
- `reset` input 1: synchronous, active-high; clears all state on the next rising edge.
- `in_data_serie_0` input 1: lane 0 serial data, MSB first.
- `in_data_serie_1` input 1: lane 1 serial data, MSB first.
- `byte_out_0` output 8: last completed lane 0 byte in the LOCKED state.
- `byte_valid_0` output 1: one-cycle pulse; `byte_out_0` holds a non-comma data byte.
- `byte_out_1` output 8: lane 1 equivalent of `byte_out_0`.
- `byte_valid_1` output 1: lane 1 equivalent of `byte_valid_0`.
- `lock_0`, `lock_1` output 1 each: the lane is in the LOCKED state.
- `active_out` output 1: `lock_0 & lock_1`.

## Operation
Each lane runs an independent FSM and operates identically.

**Lane datapath and counters**
- 8-bit shift register `sr`. Next value `sr_next = {sr[6:0], din}`, updated on every edge.
- 3-bit `bit_cnt`: the number of bits received since the last byte boundary.
- A byte completes on an edge where `bit_cnt == 7`. On that edge `bit_cnt` wraps to 0.
- Comma counter `bc_cnt`: width of `LOCK_COUNT`.

**States**
- **SEARCH:** runs a bit-by-bit sliding compare. When `sr_next == COMMA`:
  - `bit_cnt <= 0`,
  - `bc_cnt <= 1`,
  - go to ALIGN.
- **ALIGN:** compares only on byte-complete edges.
  - If `sr_next == COMMA`, increment `bc_cnt`. If the incremented value equals `LOCK_COUNT`, go to LOCKED.
  - Any other byte: go to SEARCH and set `bc_cnt <= 0`. The realigned search starts with the next bit; a mismatching byte is never re-tested as a comma.
- **LOCKED:** on each byte-complete edge:
  - `byte_out <= sr_next`,
  - `byte_valid <= (sr_next != COMMA)`.

  Commas inside LOCKED are idles. They update `byte_out` but do not assert valid. Lock is held until `reset`; there is no loss-of-lock detection.

**Outputs**
- `byte_valid` is 0 on every edge that is not a LOCKED byte-complete edge.
- `active_out` is the AND of the registered lock flags. There is no extra delay.

**Reset**
- All registers clear: `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`, state SEARCH.
- All outputs are 0.
- Reset asserted mid-lock drops `lock_x` and `active_out` on that edge.
- The bit present on the reset edge is discarded.

## Timing
- Convention: bit k after reset deassertion is sampled on rising edge k (edge 1 is the first non-reset edge).
- First comma fully received on edge 8: ALIGN is entered on edge 8.
- Later aligned commas complete on edges 16, 24, 32.
- With `LOCK_COUNT=4`, LOCKED and `lock_x` are visible after edge 32. The minimum lock latency is `8*LOCK_COUNT` bits.
- LOCKED data byte latency: `byte_out`/`byte_valid` are visible in the cycle after the edge that samples the byte's last bit.
- Both lanes lock on the same edge: `active_out` rises after that edge. Lanes lock on different edges: `active_out` rises after the later one.
- Lanes may be skewed by any number of bits. Per-lane alignment absorbs the skew; no inter-lane deskew is done here.

## Structure
- Package `phy_rx_pkg` holds:
  - `COMMA_DEFAULT = 8'hBC`,
  - `LOCK_COUNT_DEFAULT = 4`,
  - lane state encoding SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2 (2'd3 is unused and decodes to SEARCH).
- Sub-module `phy_rx_lane_sync` holds one lane's FSM, shift register and counters. It is instantiated twice.
- The top level does the `active_out` AND and port mapping only.

## Test plan
1. **Basic lock and data.** Reset for 2 cycles. Both lanes send 0xBC ×4, then 0xA5, 0x3C.
   - `lock_x` rises after edge 32.
   - `byte_valid_x` pulses after edges 40 (0xA5) and 48 (0x3C).
   - `active_out=1` after edge 32.
2. **Idle in LOCKED.** After lock, send 0xBC then 0x11.
   - 0xBC: `byte_out`=0xBC, `byte_valid`=0.
   - 0x11: `byte_valid`=1 for one cycle.
3. **Misaligned start and broken run.**
   - Lane 0 preceded by 3 junk bits `101`: lock after edge 35.
   - Lane 0 stream 0xBC, 0xBC, 0x00, then 0xBC ×4: FSM returns to SEARCH on the 0x00 byte and locks only after the second run.
4. **Lane skew.** Lane 1 delayed 5 bits relative to lane 0.
   - `lock_0` after edge 32, `lock_1` after edge 37.
   - `active_out` rises only after edge 37.
5. **Reset mid-operation.** Assert `reset` for 1 cycle while both lanes are LOCKED and streaming data.
   - All outputs are 0 on the next cycle.
   - Relock takes the full `8*LOCK_COUNT` bits after the first comma.
6. **Comma aliasing.** Stream 0x5E followed by 0x00 (bit sequence 01011110 00000000).
   - No false lock, because `LOCK_COUNT` consecutive aligned commas are required.
   - `lock_x` stays 0.

Source files
------------

// File: rtl/phy_rx_lane_ctrl_pkg.sv
// Shared constants and lane state encoding for the two-lane PHY receive controller.
package phy_rx_pkg;

  localparam logic [7:0]  COMMA_DEFAULT      = 8'hBC;
  localparam int unsigned LOCK_COUNT_DEFAULT = 4;

  typedef logic [1:0] lane_state_t;

  // 2'd3 is unused; the lane FSM treats it as SEARCH
  localparam lane_state_t SEARCH = 2'd0;
  localparam lane_state_t ALIGN  = 2'd1;
  localparam lane_state_t LOCKED = 2'd2;

endpackage

// File: rtl/phy_rx_lane_ctrl_if.sv
// Serial inputs and per-lane byte/lock outputs of the receive lane controller.
interface phy_rx_lane_ctrl_if;

  logic       in_data_serie_0;
  logic       in_data_serie_1;
  logic [7:0] byte_out_0;
  logic       byte_valid_0;
  logic [7:0] byte_out_1;
  logic       byte_valid_1;
  logic       lock_0;
  logic       lock_1;
  logic       active_out;

  modport master (
    output in_data_serie_0, in_data_serie_1,
    input  byte_out_0, byte_valid_0, byte_out_1, byte_valid_1,
    input  lock_0, lock_1, active_out
  );

  modport slave (
    input  in_data_serie_0, in_data_serie_1,
    output byte_out_0, byte_valid_0, byte_out_1, byte_valid_1,
    output lock_0, lock_1, active_out
  );

endinterface

// File: rtl/phy_rx_lane_ctrl_sync.sv
// One lane: comma search, aligned-comma run counting, and byte delivery once locked.
module phy_rx_lane_sync
  import phy_rx_pkg::*;
#(
  parameter logic [7:0]  COMMA      = COMMA_DEFAULT,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       lock
);

  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

  lane_state_t   state;
  logic [7:0]    sr;
  logic [7:0]    sr_next;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] bc_cnt;
  logic [CW-1:0] bc_inc;
  logic          byte_done;
  logic          is_comma;

  assign sr_next   = {sr[6:0], din};
  assign byte_done = (bit_cnt == 3'd7);
  assign is_comma  = (sr_next == COMMA);
  assign bc_inc    = bc_cnt + CW'(1);
  assign lock      = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SEARCH;
      sr         <= '0;
      bit_cnt    <= '0;
      bc_cnt     <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      sr         <= sr_next;
      bit_cnt    <= bit_cnt + 3'd1;
      byte_valid <= 1'b0;
      case (state)
        ALIGN: begin
          if (byte_done) begin
            if (is_comma) begin
              bc_cnt <= bc_inc;
              if (bc_inc == CW'(LOCK_COUNT)) state <= LOCKED;
            end else begin
              // restart search on the next bit; this byte is not retried
              bc_cnt <= '0;
              state  <= SEARCH;
            end
          end
        end
        LOCKED: begin
          if (byte_done) begin
            byte_out   <= sr_next;
            byte_valid <= !is_comma;
          end
        end
        default: begin
          if (is_comma) begin
            bit_cnt <= '0;
            bc_cnt  <= CW'(1);
            state   <= ALIGN;
          end else begin
            state <= SEARCH;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_lane_ctrl.sv
// Two-lane receive controller: independent per-lane sync, link active when both lanes lock.
module phy_rx_lane_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0]  COMMA      = COMMA_DEFAULT,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  phy_rx_lane_ctrl_if.slave bus
);

  logic lock_0;
  logic lock_1;

  phy_rx_lane_sync #(.COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT)) u_lane_0 (
    .clk        (clk),
    .reset      (reset),
    .din        (bus.in_data_serie_0),
    .byte_out   (bus.byte_out_0),
    .byte_valid (bus.byte_valid_0),
    .lock       (lock_0)
  );

  phy_rx_lane_sync #(.COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT)) u_lane_1 (
    .clk        (clk),
    .reset      (reset),
    .din        (bus.in_data_serie_1),
    .byte_out   (bus.byte_out_1),
    .byte_valid (bus.byte_valid_1),
    .lock       (lock_1)
  );

  assign bus.lock_0     = lock_0;
  assign bus.lock_1     = lock_1;
  assign bus.active_out = lock_0 & lock_1;

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// Randomized bench for phy_rx_lane_ctrl against a bit-history scan model of comma lock.
module tb_phy_rx_lane_ctrl;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int LC   = 4;
  localparam int MAXB = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  phy_rx_lane_ctrl_if bus();

  phy_rx_lane_ctrl #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic       sb[2][MAXB+1];
  int         nlen[2];
  logic       el[2][MAXB+1];
  logic [7:0] ebo[2][MAXB+1];
  logic       ebv[2][MAXB+1];
  logic       lock_log[2][MAXB+1];
  logic       bv_log[2][MAXB+1];
  logic [7:0] bo_log[2][MAXB+1];
  logic       act_log[MAXB+1];
  int         run_len;

  task automatic clear_streams();
    nlen[0] = 0;
    nlen[1] = 0;
  endtask

  task automatic push_bit(input int lane, input logic b);
    nlen[lane]++;
    sb[lane][nlen[lane]] = b;
  endtask

  task automatic push_byte(input int lane, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) push_bit(lane, v[i]);
  endtask

  task automatic push_both(input logic [7:0] v);
    push_byte(0, v);
    push_byte(1, v);
  endtask

  task automatic push_rand(input int lane, input int nbytes);
    for (int i = 0; i < nbytes; i++) push_byte(lane, 8'($urandom_range(0, 255)));
  endtask

  // The 8 bits ending at edge e (bits before edge 1 are the reset-cleared zeros)
  function automatic logic [7:0] win(input int lane, input int e);
    logic [7:0] w;
    int idx;
    for (int i = 0; i < 8; i++) begin
      idx = e - 7 + i;
      w[7-i] = (idx >= 1) ? sb[lane][idx] : 1'b0;
    end
    return w;
  endfunction

  // Lock edge = end of the first run of LC commas spaced exactly 8 bits apart,
  // where a broken run resumes sliding search one bit after the offending byte.
  task automatic model(input int lane, input int n);
    int s, e, m, cnt, lock_edge;
    logic done;
    logic [7:0] bo;
    s = 1; lock_edge = 0; done = 1'b0;
    while (!done && s <= n) begin
      e = s;
      while (e <= n && win(lane, e) != COMMA) e++;
      if (e > n) done = 1'b1;
      else begin
        cnt = 1; m = e;
        while (cnt < LC && m + 8 <= n && win(lane, m + 8) == COMMA) begin
          m += 8;
          cnt++;
        end
        if (cnt == LC) begin
          lock_edge = m;
          done = 1'b1;
        end else if (m + 8 > n) done = 1'b1;
        else s = m + 9;
      end
    end
    bo = 8'h00;
    for (int t = 1; t <= n; t++) begin
      ebv[lane][t] = 1'b0;
      if (lock_edge != 0 && t > lock_edge && (t - lock_edge) % 8 == 0) begin
        bo = win(lane, t);
        ebv[lane][t] = (bo != COMMA);
      end
      ebo[lane][t] = bo;
      el[lane][t]  = (lock_edge != 0) && (t >= lock_edge);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    bus.in_data_serie_0 = 1'($urandom);
    bus.in_data_serie_1 = 1'($urandom);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_zero(input string name);
    tests_run += 7;
    if (bus.lock_0 !== 1'b0)       begin tests_failed++; $display("FAIL %s lock_0 got %b want 0", name, bus.lock_0); end
    if (bus.lock_1 !== 1'b0)       begin tests_failed++; $display("FAIL %s lock_1 got %b want 0", name, bus.lock_1); end
    if (bus.active_out !== 1'b0)   begin tests_failed++; $display("FAIL %s active_out got %b want 0", name, bus.active_out); end
    if (bus.byte_out_0 !== 8'h00)  begin tests_failed++; $display("FAIL %s byte_out_0 got %h want 00", name, bus.byte_out_0); end
    if (bus.byte_out_1 !== 8'h00)  begin tests_failed++; $display("FAIL %s byte_out_1 got %h want 00", name, bus.byte_out_1); end
    if (bus.byte_valid_0 !== 1'b0) begin tests_failed++; $display("FAIL %s byte_valid_0 got %b want 0", name, bus.byte_valid_0); end
    if (bus.byte_valid_1 !== 1'b0) begin tests_failed++; $display("FAIL %s byte_valid_1 got %b want 0", name, bus.byte_valid_1); end
  endtask

  // Pads lanes to equal length with random bits, then drives and checks every edge.
  task automatic run_stream(input string name);
    logic act_exp;
    while (nlen[0] < nlen[1]) push_bit(0, 1'($urandom));
    while (nlen[1] < nlen[0]) push_bit(1, 1'($urandom));
    run_len = nlen[0];
    model(0, run_len);
    model(1, run_len);
    for (int t = 1; t <= run_len; t++) begin
      bus.in_data_serie_0 = sb[0][t];
      bus.in_data_serie_1 = sb[1][t];
      @(posedge clk);
      #1;
      lock_log[0][t] = bus.lock_0;
      lock_log[1][t] = bus.lock_1;
      bv_log[0][t] = bus.byte_valid_0;
      bv_log[1][t] = bus.byte_valid_1;
      bo_log[0][t] = bus.byte_out_0;
      bo_log[1][t] = bus.byte_out_1;
      act_log[t] = bus.active_out;
      act_exp = el[0][t] & el[1][t];
      tests_run += 7;
      if (bus.lock_0 !== el[0][t]) begin tests_failed++; $display("FAIL %s edge %0d lock_0 got %b want %b", name, t, bus.lock_0, el[0][t]); end
      if (bus.lock_1 !== el[1][t]) begin tests_failed++; $display("FAIL %s edge %0d lock_1 got %b want %b", name, t, bus.lock_1, el[1][t]); end
      if (bus.active_out !== act_exp) begin tests_failed++; $display("FAIL %s edge %0d active_out got %b want %b", name, t, bus.active_out, act_exp); end
      if (bus.byte_out_0 !== ebo[0][t]) begin tests_failed++; $display("FAIL %s edge %0d byte_out_0 got %h want %h", name, t, bus.byte_out_0, ebo[0][t]); end
      if (bus.byte_out_1 !== ebo[1][t]) begin tests_failed++; $display("FAIL %s edge %0d byte_out_1 got %h want %h", name, t, bus.byte_out_1, ebo[1][t]); end
      if (bus.byte_valid_0 !== ebv[0][t]) begin tests_failed++; $display("FAIL %s edge %0d byte_valid_0 got %b want %b", name, t, bus.byte_valid_0, ebv[0][t]); end
      if (bus.byte_valid_1 !== ebv[1][t]) begin tests_failed++; $display("FAIL %s edge %0d byte_valid_1 got %b want %b", name, t, bus.byte_valid_1, ebv[1][t]); end
    end
  endtask

  task automatic spot(input string name, input logic got, input logic want);
    tests_run++;
    if (got !== want) begin tests_failed++; $display("FAIL %s got %b want %b", name, got, want); end
  endtask

  task automatic test_reset();
    do_reset(2);
    check_zero("reset");
  endtask

  task automatic test_basic_lock();
    do_reset(2);
    clear_streams();
    repeat (4) push_both(COMMA);
    push_both(8'hA5);
    push_both(8'h3C);
    push_rand(0, 6);
    push_rand(1, 6);
    run_stream("basic");
    spot("basic lock_0@31", lock_log[0][31], 1'b0);
    spot("basic lock_0@32", lock_log[0][32], 1'b1);
    spot("basic active@32", act_log[32], 1'b1);
    spot("basic valid_0@40", bv_log[0][40], 1'b1);
    spot("basic byte_0@40 is A5", bo_log[0][40] == 8'hA5, 1'b1);
    spot("basic valid_1@41", bv_log[1][41], 1'b0);
    spot("basic byte_1@48 is 3C", bo_log[1][48] == 8'h3C, 1'b1);
  endtask

  task automatic test_idle();
    do_reset(2);
    clear_streams();
    repeat (5) push_both(COMMA);
    push_both(8'h11);
    push_rand(0, 4);
    push_rand(1, 4);
    run_stream("idle");
    spot("idle valid_0@40", bv_log[0][40], 1'b0);
    spot("idle byte_0@40 is BC", bo_log[0][40] == COMMA, 1'b1);
    spot("idle valid_0@48", bv_log[0][48], 1'b1);
    spot("idle valid_0@49", bv_log[0][49], 1'b0);
  endtask

  task automatic test_misaligned();
    do_reset(2);
    clear_streams();
    push_bit(0, 1'b1); push_bit(0, 1'b0); push_bit(0, 1'b1);
    repeat (4) push_byte(0, COMMA);
    repeat (4) push_byte(1, COMMA);
    push_rand(0, 5);
    push_rand(1, 5);
    run_stream("misaligned");
    spot("misaligned lock_0@34", lock_log[0][34], 1'b0);
    spot("misaligned lock_0@35", lock_log[0][35], 1'b1);
    spot("misaligned active@34", act_log[34], 1'b0);
  endtask

  task automatic test_broken_run();
    do_reset(2);
    clear_streams();
    push_byte(0, COMMA); push_byte(0, COMMA); push_byte(0, 8'h00);
    repeat (4) push_byte(0, COMMA);
    repeat (4) push_byte(1, COMMA);
    push_rand(0, 4);
    push_rand(1, 7);
    run_stream("broken");
    spot("broken lock_0@32", lock_log[0][32], 1'b0);
    spot("broken lock_0@55", lock_log[0][55], 1'b0);
    spot("broken lock_0@56", lock_log[0][56], 1'b1);
  endtask

  task automatic test_skew();
    do_reset(2);
    clear_streams();
    repeat (5) push_bit(1, 1'b0);
    repeat (4) push_byte(0, COMMA);
    repeat (4) push_byte(1, COMMA);
    push_rand(0, 6);
    push_rand(1, 6);
    run_stream("skew");
    spot("skew lock_0@32", lock_log[0][32], 1'b1);
    spot("skew lock_1@36", lock_log[1][36], 1'b0);
    spot("skew lock_1@37", lock_log[1][37], 1'b1);
    spot("skew active@36", act_log[36], 1'b0);
    spot("skew active@37", act_log[37], 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    clear_streams();
    repeat (4) push_both(COMMA);
    push_rand(0, 4);
    push_rand(1, 4);
    run_stream("pre_reset");
    reset = 1'b1;
    bus.in_data_serie_0 = 1'($urandom);
    bus.in_data_serie_1 = 1'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero("mid_reset");
    clear_streams();
    repeat (4) push_both(COMMA);
    push_rand(0, 3);
    push_rand(1, 3);
    run_stream("relock");
    spot("relock lock_0@31", lock_log[0][31], 1'b0);
    spot("relock active@32", act_log[32], 1'b1);
  endtask

  task automatic test_alias();
    do_reset(2);
    clear_streams();
    repeat (8) begin
      push_both(8'h5E);
      push_both(8'h00);
    end
    run_stream("alias");
    spot("alias lock_0 end", lock_log[0][run_len], 1'b0);
    spot("alias lock_1 end", lock_log[1][run_len], 1'b0);
  endtask

  task automatic test_random();
    int runs;
    for (int it = 0; it < 6; it++) begin
      do_reset(1 + int'($urandom_range(0, 2)));
      clear_streams();
      for (int l = 0; l < 2; l++) begin
        runs = int'($urandom_range(0, 15));
        for (int b = 0; b < runs; b++) push_bit(l, 1'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          push_byte(l, COMMA);
          push_byte(l, 8'($urandom_range(0, 255)));
        end
        repeat (4) push_byte(l, COMMA);
        push_rand(l, 10);
      end
      run_stream("random");
    end
  endtask

  initial begin
    bus.in_data_serie_0 = 1'b0;
    bus.in_data_serie_1 = 1'b0;
    test_reset();
    test_basic_lock();
    test_idle();
    test_misaligned();
    test_broken_run();
    test_skew();
    test_reset_mid();
    test_alias();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
